// File: rtl/p2s_lane_serializer.sv
// ---------------------------------------------------------------------------
// p2s_lane_serializer
//
// Multi-lane parallel-to-serial converter. Each of LANES lanes takes a
// WIDTH-bit slice of the input word and shifts it out one bit per clock. All
// lanes run in lockstep. A one-word holding register sits in front of the
// shifter, so a new word can be accepted while the current one is still being
// shifted. This lets words stream back-to-back with no output bubble.
//
// Parameters:
//   LANES      number of parallel lanes (>= 1)
//   WIDTH      bits per lane word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
//   IW         width of bit_idx (derived)
//
// Ports:
//   CLK        clock; all state changes on the rising edge
//   reset      synchronous, active-high; clears all state
//   ENB        enable; low freezes all state and blanks the serial outputs
//   D          input word; lane i = D[i*WIDTH +: WIDTH]
//   in_valid   D is valid
//   in_ready   block accepts D this cycle
//   data_out   current serial bit of each lane (0 when not valid)
//   out_valid  data_out carries a valid bit
//   sof        first bit of a word is on data_out
//   eof        last bit of a word is on data_out
//   bit_idx    index of the current bit within the word
// ---------------------------------------------------------------------------
module p2s_lane_serializer #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned IW        = $clog2(WIDTH)
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   ENB,
    input  logic [LANES*WIDTH-1:0] D,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [LANES-1:0]       data_out,
    output logic                   out_valid,
    output logic                   sof,
    output logic                   eof,
    output logic [IW-1:0]          bit_idx
);

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_SHIFT = 1'b1;

    localparam logic [IW-1:0] CNT_LAST = IW'(WIDTH - 1);

    logic                   r_state;
    logic                   r_hold_full;
    logic [LANES*WIDTH-1:0] r_hold;
    logic [LANES*WIDTH-1:0] r_shreg;
    logic [IW-1:0]          r_cnt;

    logic                   w_in_ready;
    logic                   w_accept;
    logic                   w_last;
    logic                   w_load;
    logic                   w_advance;
    logic                   w_finish;
    logic [LANES*WIDTH-1:0] w_shifted;
    logic [LANES-1:0]       w_head;

    // Per-lane shift toward the output end and selection of the output bit.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if (MSB_FIRST) begin : g_msb
            assign w_shifted[g*WIDTH +: WIDTH] = {r_shreg[g*WIDTH +: WIDTH-1], 1'b0};
            assign w_head[g]                   = r_shreg[g*WIDTH + WIDTH - 1];
        end else begin : g_lsb
            assign w_shifted[g*WIDTH +: WIDTH] = {1'b0, r_shreg[g*WIDTH + 1 +: WIDTH-1]};
            assign w_head[g]                   = r_shreg[g*WIDTH];
        end
    end

    always_comb begin
        w_in_ready = ENB & ~r_hold_full;
        w_accept   = in_valid & w_in_ready;
        w_last     = (r_cnt == CNT_LAST);
        // Load on an idle shifter, or reload at the last bit of the current
        // word. The reload keeps the output stream free of bubbles.
        w_load     = ENB & r_hold_full & ((r_state == S_IDLE) | w_last);
        w_advance  = ENB & (r_state == S_SHIFT) & ~w_last;
        w_finish   = ENB & (r_state == S_SHIFT) & w_last & ~r_hold_full;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_shreg     <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_hold <= D;
            end

            // in_ready depends on the registered flag, so accept and load
            // are mutually exclusive and the held word is never overwritten.
            if (w_accept) begin
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end

            if (w_load) begin
                r_shreg <= r_hold;
                r_cnt   <= '0;
                r_state <= S_SHIFT;
            end else if (w_advance) begin
                r_shreg <= w_shifted;
                r_cnt   <= r_cnt + IW'(1);
            end else if (w_finish) begin
                r_state <= S_IDLE;
            end
        end
    end

    always_comb begin
        in_ready  = w_in_ready;
        out_valid = (r_state == S_SHIFT) & ENB;
        data_out  = out_valid ? w_head : '0;
        sof       = out_valid & (r_cnt == '0);
        eof       = out_valid & w_last;
        bit_idx   = r_cnt;
    end

endmodule

// File: tb/tb_p2s_lane_serializer.sv
// Directed bench for p2s_lane_serializer. Two instances share one stimulus:
// one shifts MSB first, the other LSB first. Inputs change 1 time unit after
// the rising edge. Outputs are sampled on the falling edge.
module tb_p2s_lane_serializer;

    logic        CLK = 1'b0;
    logic        reset;
    logic        ENB;
    logic        in_valid;
    logic [31:0] D;

    logic       m_ready, m_ov, m_sof, m_eof;
    logic [3:0] m_data;
    logic [2:0] m_idx;
    logic       l_ready, l_ov, l_sof, l_eof;
    logic [3:0] l_data;
    logic [2:0] l_idx;

    int n_assert = 0;
    int n_fail   = 0;
    int vcount;

    p2s_lane_serializer #(
        .LANES     (4),
        .WIDTH     (8),
        .MSB_FIRST (1'b1)
    ) u_msb (
        .CLK       (CLK),
        .reset     (reset),
        .ENB       (ENB),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (m_ready),
        .data_out  (m_data),
        .out_valid (m_ov),
        .sof       (m_sof),
        .eof       (m_eof),
        .bit_idx   (m_idx)
    );

    p2s_lane_serializer #(
        .LANES     (4),
        .WIDTH     (8),
        .MSB_FIRST (1'b0)
    ) u_lsb (
        .CLK       (CLK),
        .reset     (reset),
        .ENB       (ENB),
        .D         (D),
        .in_valid  (in_valid),
        .in_ready  (l_ready),
        .data_out  (l_data),
        .out_valid (l_ov),
        .sof       (l_sof),
        .eof       (l_eof),
        .bit_idx   (l_idx)
    );

    always #5 CLK = ~CLK;

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // idx < 0 skips the bit_idx check (its idle value after a word is not pinned).
    task automatic expect_cycle(input string tag, input logic ov, input logic s, input logic e,
                                input int idx, input logic [3:0] dm, input logic [3:0] dl,
                                input logic rdy);
        chk({tag, ".m_out_valid"}, 32'(m_ov), 32'(ov));
        chk({tag, ".l_out_valid"}, 32'(l_ov), 32'(ov));
        chk({tag, ".m_sof"}, 32'(m_sof), 32'(s));
        chk({tag, ".l_sof"}, 32'(l_sof), 32'(s));
        chk({tag, ".m_eof"}, 32'(m_eof), 32'(e));
        chk({tag, ".l_eof"}, 32'(l_eof), 32'(e));
        chk({tag, ".m_data"}, 32'(m_data), 32'(dm));
        chk({tag, ".l_data"}, 32'(l_data), 32'(dl));
        chk({tag, ".m_in_ready"}, 32'(m_ready), 32'(rdy));
        chk({tag, ".l_in_ready"}, 32'(l_ready), 32'(rdy));
        if (idx >= 0) begin
            chk({tag, ".m_bit_idx"}, 32'(m_idx), 32'(idx));
            chk({tag, ".l_bit_idx"}, 32'(l_idx), 32'(idx));
        end
    endtask

    // Eight shifting cycles of one word; seq_* lists output nibbles first-to-last.
    task automatic word_check(input string tag, input logic [31:0] seq_m,
                              input logic [31:0] seq_l, input logic rdy);
        for (int j = 0; j < 8; j++) begin
            cyc();
            smp();
            expect_cycle($sformatf("%s[%0d]", tag, j), 1'b1, j == 0, j == 7, j,
                         seq_m[31-4*j -: 4], seq_l[31-4*j -: 4], rdy);
        end
    endtask

    initial begin
        logic [31:0] seq_m;
        logic [31:0] seq_l;

        reset    = 1'b1;
        ENB      = 1'b1;
        in_valid = 1'b0;
        D        = '0;

        // Reset and idle
        repeat (2) @(posedge CLK);
        #1;
        smp();
        expect_cycle("reset", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1);

        // Single word 01234567
        cyc(); reset = 1'b0; in_valid = 1'b1; D = 32'h0123_4567;
        smp(); expect_cycle("sw_acc", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1);
        cyc(); in_valid = 1'b0;
        smp(); expect_cycle("sw_hold", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b0);
        word_check("sw", 32'h0350_035F, 32'hF530_0530, 1'b1);
        cyc();
        smp(); expect_cycle("sw_end", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);

        // Back-to-back 89ABCDEF then FFFFFFFF
        cyc(); in_valid = 1'b1; D = 32'h89AB_CDEF;
        smp(); expect_cycle("b2b_acc", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);
        cyc(); D = 32'hFFFF_FFFF;
        smp(); expect_cycle("b2b_hold", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < 16; j++) begin
            cyc();
            in_valid = (j == 0);
            seq_m = (j < 8) ? 32'hF350_F35F : 32'hFFFF_FFFF;
            seq_l = (j < 8) ? 32'hF53F_053F : 32'hFFFF_FFFF;
            smp();
            expect_cycle($sformatf("b2b[%0d]", j), 1'b1, (j % 8) == 0, (j % 8) == 7, j % 8,
                         seq_m[31-4*(j%8) -: 4], seq_l[31-4*(j%8) -: 4],
                         (j == 0) || (j >= 8));
        end
        cyc();
        smp(); expect_cycle("b2b_end", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);

        // Enable freeze at bit_idx 3 of AAAAAAAA
        seq_m  = 32'hF0F0_F0F0;
        seq_l  = 32'h0F0F_0F0F;
        vcount = 0;
        cyc(); in_valid = 1'b1; D = 32'hAAAA_AAAA;
        smp(); expect_cycle("frz_acc", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);
        cyc(); in_valid = 1'b0;
        smp(); expect_cycle("frz_hold", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < 3; j++) begin
            cyc();
            smp();
            expect_cycle($sformatf("frz_pre[%0d]", j), 1'b1, j == 0, 1'b0, j,
                         seq_m[31-4*j -: 4], seq_l[31-4*j -: 4], 1'b1);
            vcount += int'(m_ov);
        end
        for (int f = 0; f < 6; f++) begin
            cyc();
            ENB = 1'b0;
            smp();
            expect_cycle($sformatf("frz_off[%0d]", f), 1'b0, 1'b0, 1'b0, 3, 4'h0, 4'h0, 1'b0);
            vcount += int'(m_ov);
        end
        for (int j = 3; j < 8; j++) begin
            cyc();
            ENB = 1'b1;
            smp();
            expect_cycle($sformatf("frz_post[%0d]", j), 1'b1, 1'b0, j == 7, j,
                         seq_m[31-4*j -: 4], seq_l[31-4*j -: 4], 1'b1);
            vcount += int'(m_ov);
        end
        chk("frz_valid_count", 32'(vcount), 32'd8);
        cyc();
        smp(); expect_cycle("frz_end", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);

        // Reset mid-word at bit_idx 5 of 55555555 with FEDCBA98 held
        seq_m = 32'h0F0F_0F0F;
        seq_l = 32'hF0F0_F0F0;
        cyc(); in_valid = 1'b1; D = 32'h5555_5555;
        smp(); expect_cycle("rm_acc", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);
        cyc(); D = 32'hFEDC_BA98;
        smp(); expect_cycle("rm_hold", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            cyc();
            in_valid = (j == 0);
            smp();
            expect_cycle($sformatf("rm[%0d]", j), 1'b1, j == 0, 1'b0, j,
                         seq_m[31-4*j -: 4], seq_l[31-4*j -: 4], j == 0);
        end
        cyc(); reset = 1'b1;
        smp(); expect_cycle("rm_at5", 1'b1, 1'b0, 1'b0, 5, 4'hF, 4'h0, 1'b0);
        cyc(); reset = 1'b0;
        smp(); expect_cycle("rm_after", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            cyc();
            smp();
            expect_cycle($sformatf("rm_idle[%0d]", k), 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1);
        end
        cyc(); in_valid = 1'b1; D = 32'h0123_4567;
        smp(); expect_cycle("rm_new_acc", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b1);
        cyc(); in_valid = 1'b0;
        smp(); expect_cycle("rm_new_hold", 1'b0, 1'b0, 1'b0, 0, 4'h0, 4'h0, 1'b0);
        word_check("rm_new", 32'h0350_035F, 32'hF530_0530, 1'b1);
        cyc();
        smp(); expect_cycle("rm_new_end", 1'b0, 1'b0, 1'b0, -1, 4'h0, 4'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
